alu_mdu_seq: RTL
================

// Module: alu_mdu_seq
// PURPOSE
//  Successor to the single-cycle ALU: a registered execute unit performing all base ALU ops
//  plus RV32M multiply/divide (iterative, one bit per cycle), behind valid/ready handshakes.
//  Sits in EX; the pipeline stalls on in_ready/out_valid. Result and status are registered outputs.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width (>=8, even)
//  OPCODE_LENGTH  5   Operation width; bit 4 selects M-ext, bits[3:0] = base ALU encoding
//  SHAMT_W        $clog2(DATA_WIDTH)  shift amount bits taken from SrcB
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  flush      in   1           sync abort of any in-flight or held op
//  in_valid   in   1           operands/op valid
//  in_ready   out  1           unit can accept
//  SrcA       in   DATA_WIDTH  operand A (signed)
//  SrcB       in   DATA_WIDTH  operand B (signed)
//  Operation  in   OPCODE_LENGTH  op select
//  out_valid  out  1           ALUResult valid
//  out_ready  in   1           consumer takes result
//  ALUResult  out  DATA_WIDTH  registered result
//  DivByZero  out  1           registered; 1 when DIV/DIVU/REM/REMU had SrcB==0
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, out_valid=0, ALUResult=0, DivByZero=0, datapath regs 0.
//  Base ops (Operation[4]=0): 0000 AND, 0001 OR, 0110 XOR, 1001 NOR, 0010 ADD, 0011 SUB,
//   0100 SLL, 0111 SRL, 1000 SRA (shift by SrcB[SHAMT_W-1:0]), 0101 SLT, 1100 SLTU,
//   1010 EQ, 1011 NE (0/1 results); other codes -> 0. Mod 2^DATA_WIDTH arithmetic, no flags.
//  M ops (Operation[4]=1): 0000 MUL(low), 0001 MULH(s*s), 0010 MULHSU(s*u), 0011 MULHU,
//   0100 DIV, 0101 DIVU, 0110 REM, 0111 REMU; 1xxx -> result 0 with base-op latency.
//  FSM: IDLE, BUSY, DONE. Handshake fires when in_valid & in_ready.
//   IDLE: fire+base/unknown -> DONE (result regs load at that edge; latency 1).
//         fire+M op -> BUSY, iter counter = DATA_WIDTH, operands latched (signs -> magnitudes).
//   BUSY: one shift-add / restoring-subtract step per cycle; counter hits 0 -> DONE with
//         sign fix-up applied; M-op latency fixed = DATA_WIDTH+1 cycles, independent of data.
//   DONE: out_valid=1; ALUResult/DivByZero held stable until out_ready=1.
//         out_ready & fire -> accept new op (same rules as IDLE); out_ready & !fire -> IDLE.
//  in_ready = (state==IDLE) | (state==DONE & out_ready) ; never high in BUSY; 0 when flush=1.
//  Operands are sampled only on the fire edge; SrcA/SrcB changes in BUSY have no effect.
//  Corner cases: DIV/REM by 0: quotient = all ones, remainder = SrcA, DivByZero=1.
//   DIV signed overflow (SrcA=MIN, SrcB=-1): quotient = MIN, REM = 0, DivByZero=0.
//   MULH* use full 2*DATA_WIDTH product; sign handling per RV32M.
//  flush=1 at any edge: state->IDLE, out_valid->0 next cycle, result regs keep value, in-flight
//   op discarded; flush has priority over fire and out_ready.
//  rst_n low mid-BUSY: immediate abort, all outputs to reset values.
// TESTING
//  ADD 7+(-3), out_ready=1 -> out_valid 1 cycle after fire, ALUResult=4; SRA 0x80000000>>4 -> 0xF8000000.
//  MUL 0xFFFFFFFF*0xFFFFFFFF: MUL=1, MULHU=0xFFFFFFFE, MULH=0, MULHSU=0xFFFFFFFF; each 33 cycles.
//  DIV -7/2 -> -3, REM -7/2 -> -1; DIVU 5/0 -> 0xFFFFFFFF, DivByZero=1; REMU 5/0 -> 5.
//  DIV 0x80000000/-1 -> 0x80000000, REM -> 0, DivByZero=0; in_ready=0 all 32 BUSY cycles.
//  out_ready held 0 for 5 cycles in DONE -> ALUResult stable, in_ready=0; then back-to-back ops
//   with out_ready=1 -> one base result per cycle, no bubble.
//  flush at BUSY cycle 10 -> out_valid never asserts, in_ready=1 next cycle; rst_n pulse mid-DIV
//   -> out_valid=0, ALUResult=0 immediately.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: registered execute unit. Base ALU ops complete in one cycle;
// RV32M multiply/divide run iteratively, one bit per cycle, with a fixed
// DATA_WIDTH+1 cycle latency.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous abort of any in-flight or held op
//   in_valid/in_ready   request handshake (fires when both high)
//   SrcA, SrcB          operands, sampled only on the fire edge
//   Operation           [4] selects M extension, [3:0] base ALU encoding
//   out_valid/out_ready result handshake
//   ALUResult           registered result
//   DivByZero           registered, set when DIV/DIVU/REM/REMU had SrcB==0
//
// state | meaning
// IDLE  | no op held, ready for a new one
// BUSY  | iterating a multiply/divide, one step per cycle
// DONE  | result presented, waiting for out_ready
module alu_mdu_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5,
    parameter int SHAMT_W       = $clog2(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     DivByZero
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     hi_q, lo_q, b_q, a_q, res_q;
    logic [2:0]       op_q;
    logic             neg_q, rneg_q, dbz_q, dbz_out_q;

    logic             fire, is_mop, last_step;
    logic [W-1:0]     base_res, a_mag, b_mag, mul_add, hi_d, lo_d, final_res;
    logic             a_sgn, b_sgn, a_neg, b_neg, div_ge;
    logic [W:0]       mul_sum, div_sh, div_sub;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quo_fix, rem_fix;
    logic [SHAMT_W-1:0] shamt;

    assign fire      = in_valid & in_ready;
    assign is_mop    = Operation[4] & ~Operation[3];
    assign last_step = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));
    assign shamt     = SrcB[SHAMT_W-1:0];

    // Base ALU; M-space unknown codes (1xxxx with bit 3 set) also land on 0 here.
    always_comb begin
        base_res = '0;
        if (!Operation[4]) begin
            case (Operation[3:0])
                4'b0000: base_res = SrcA & SrcB;
                4'b0001: base_res = SrcA | SrcB;
                4'b0110: base_res = SrcA ^ SrcB;
                4'b1001: base_res = ~(SrcA | SrcB);
                4'b0010: base_res = SrcA + SrcB;
                4'b0011: base_res = SrcA - SrcB;
                4'b0100: base_res = SrcA << shamt;
                4'b0111: base_res = SrcA >> shamt;
                4'b1000: base_res = $signed(SrcA) >>> shamt;
                4'b0101: base_res = W'($signed(SrcA) < $signed(SrcB));
                4'b1100: base_res = W'(SrcA < SrcB);
                4'b1010: base_res = W'(SrcA == SrcB);
                4'b1011: base_res = W'(SrcA != SrcB);
                default: base_res = '0;
            endcase
        end
    end

    // Operand signedness: MULHSU treats only A as signed, MULHU/DIVU/REMU neither.
    always_comb begin
        a_sgn = Operation[2] ? ~Operation[0] : ~(Operation[1] & Operation[0]);
        b_sgn = Operation[2] ? ~Operation[0] : ~Operation[1];
        a_neg = a_sgn & SrcA[W-1];
        b_neg = b_sgn & SrcB[W-1];
        a_mag = a_neg ? -SrcA : SrcA;
        b_mag = b_neg ? -SrcB : SrcB;
    end

    // One iteration: shift-add for multiply ({hi,lo} is the product/multiplier
    // pair), restoring subtract for divide (hi = remainder, lo = quotient).
    always_comb begin
        mul_add = lo_q[0] ? b_q : '0;
        mul_sum = {1'b0, hi_q} + {1'b0, mul_add};
        div_sh  = {hi_q, lo_q[W-1]};
        div_ge  = div_sh >= {1'b0, b_q};
        div_sub = div_sh - {1'b0, b_q};
        if (op_q[2]) begin
            hi_d = div_ge ? div_sub[W-1:0] : div_sh[W-1:0];
            lo_d = {lo_q[W-2:0], div_ge};
        end else begin
            hi_d = mul_sum[W:1];
            lo_d = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    // Sign fix-up is applied to the last step's output so the result lands on
    // the same edge as the final iteration.
    always_comb begin
        prod_fix = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        quo_fix  = neg_q ? -lo_d : lo_d;
        rem_fix  = rneg_q ? -hi_d : hi_d;
        case (op_q)
            3'b000:          final_res = prod_fix[W-1:0];
            3'b001, 3'b010,
            3'b011:          final_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:  final_res = dbz_q ? '1 : quo_fix;
            default:         final_res = dbz_q ? a_q : rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (fire) state_d = is_mop ? S_BUSY : S_DONE;
            S_BUSY: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE: begin
                if (fire)           state_d = is_mop ? S_BUSY : S_DONE;
                else if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        in_ready  = !flush && ((state_q == S_IDLE) || (state_q == S_DONE && out_ready));
        out_valid = (state_q == S_DONE);
    end

    // Datapath; flush leaves everything as is, only the state returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            a_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            res_q     <= '0;
            dbz_out_q <= 1'b0;
        end else if (!flush) begin
            if (fire) begin
                if (is_mop) begin
                    hi_q   <= '0;
                    lo_q   <= a_mag;
                    b_q    <= b_mag;
                    a_q    <= SrcA;
                    op_q   <= Operation[2:0];
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    dbz_q  <= (SrcB == '0);
                    cnt_q  <= CNT_W'(W);
                end else begin
                    res_q     <= base_res;
                    dbz_out_q <= 1'b0;
                end
            end else if (state_q == S_BUSY) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last_step) begin
                    res_q     <= final_res;
                    dbz_out_q <= op_q[2] & dbz_q;
                end
            end
        end
    end

    assign ALUResult = res_q;
    assign DivByZero = dbz_out_q;
endmodule
